riscv_ctrl_fsm: RTL and testbench

- Multicycle control unit for the RV32I core: the producer side of the ALU op_code/operand-select interface.
- Sequences fetch, decode, execute, memory and writeback for the supported subset.
- Drives ALU operation, operand muxes, register-file/PC/IR write enables and a req/ack memory handshake.
- Sits between the instruction register and the shared datapath (ALU, ALU-out register, register file, unified memory port).

---
 rtl/riscv_ctrl_fsm.sv | 250 +++++++++++++++++++++++++
 tb/tb_riscv_ctrl_fsm.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_ctrl_fsm.sv
// Multicycle RV32I control unit: sequences fetch/decode/execute/memory/writeback and
// drives the ALU op, operand selects, write enables and the req/ack memory handshake.
module riscv_ctrl_fsm #(
    parameter int ALU_OP_W = 3,
    parameter int STATE_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         instr,
    input  logic                mem_ack,
    input  logic                alu_zero,
    output logic                mem_req,
    output logic                mem_we,
    output logic                mem_addr_sel,
    output logic                ir_we,
    output logic                pc_we,
    output logic                pc_sel,
    output logic [1:0]          alu_src_a_sel,
    output logic [1:0]          alu_src_b_sel,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          result_sel,
    output logic                rf_we,
    output logic                illegal,
    output logic [STATE_W-1:0]  state
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_LUI       = 4'd11,
        S_TRAP      = 4'd12
    } state_t;

    localparam logic [ALU_OP_W-1:0] OP_ADD  = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] OP_OR   = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] OP_SRL  = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] OP_SLL  = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] OP_SLTU = ALU_OP_W'(4);
    localparam logic [ALU_OP_W-1:0] OP_SUB  = ALU_OP_W'(5);
    localparam logic [ALU_OP_W-1:0] OP_SRC1 = ALU_OP_W'(6);

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [1:0] A_PC     = 2'd0;
    localparam logic [1:0] A_RS1    = 2'd1;
    localparam logic [1:0] A_OLD_PC = 2'd2;
    localparam logic [1:0] A_ZERO   = 2'd3;
    localparam logic [1:0] B_RS2    = 2'd0;
    localparam logic [1:0] B_IMM    = 2'd1;
    localparam logic [1:0] B_FOUR   = 2'd2;
    localparam logic [1:0] RES_ALU_OUT = 2'd0;
    localparam logic [1:0] RES_MEM     = 2'd1;
    localparam logic [1:0] RES_ALU     = 2'd2;

    state_t     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_instr_bits;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

    // Shift encodings need funct7 clear; only ADD has an alternate (SUB) form.
    function automatic logic r_legal(input logic [2:0] f3, input logic [6:0] f7);
        case (f3)
            3'b000:                      return (f7 == 7'b0000000) || (f7 == 7'b0100000);
            3'b001, 3'b011, 3'b101, 3'b110: return (f7 == 7'b0000000);
            default:                     return 1'b0;
        endcase
    endfunction

    function automatic logic i_legal(input logic [2:0] f3, input logic [6:0] f7);
        case (f3)
            3'b000, 3'b011, 3'b110: return 1'b1;
            3'b001, 3'b101:         return (f7 == 7'b0000000);
            default:                return 1'b0;
        endcase
    endfunction

    function automatic logic [ALU_OP_W-1:0] r_op(input logic [2:0] f3, input logic [6:0] f7);
        case (f3)
            3'b000:  return f7[5] ? OP_SUB : OP_ADD;
            3'b110:  return OP_OR;
            3'b001:  return OP_SLL;
            3'b101:  return OP_SRL;
            3'b011:  return OP_SLTU;
            default: return OP_ADD;
        endcase
    endfunction

    function automatic logic [ALU_OP_W-1:0] i_op(input logic [2:0] f3);
        case (f3)
            3'b110:  return OP_OR;
            3'b001:  return OP_SLL;
            3'b101:  return OP_SRL;
            3'b011:  return OP_SLTU;
            default: return OP_ADD;
        endcase
    endfunction

    always_comb begin
        state_d       = state_q;
        illegal_d     = illegal_q;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr_sel  = 1'b0;
        ir_we         = 1'b0;
        pc_we         = 1'b0;
        pc_sel        = 1'b0;
        alu_src_a_sel = A_PC;
        alu_src_b_sel = B_RS2;
        alu_op        = OP_ADD;
        result_sel    = RES_ALU_OUT;
        rf_we         = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req       = 1'b1;
                alu_src_a_sel = A_PC;
                alu_src_b_sel = B_FOUR;
                if (mem_ack) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch/JAL target is computed here and captured in the ALU-out register.
                alu_src_a_sel = A_OLD_PC;
                alu_src_b_sel = B_IMM;
                case (opcode)
                    OPC_R:               state_d = r_legal(funct3, funct7) ? S_EXEC_R : S_TRAP;
                    OPC_I:               state_d = i_legal(funct3, funct7) ? S_EXEC_I : S_TRAP;
                    OPC_LOAD, OPC_STORE: state_d = S_MEM_ADDR;
                    OPC_BRANCH:          state_d = (funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
                    OPC_JAL:             state_d = S_JAL;
                    OPC_LUI:             state_d = S_LUI;
                    default:             state_d = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                alu_src_a_sel = A_RS1;
                alu_src_b_sel = B_RS2;
                alu_op        = r_op(funct3, funct7);
                state_d       = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a_sel = A_RS1;
                alu_src_b_sel = B_IMM;
                alu_op        = i_op(funct3);
                state_d       = S_ALU_WB;
            end
            S_LUI: begin
                alu_src_a_sel = A_ZERO;
                alu_src_b_sel = B_IMM;
                state_d       = S_ALU_WB;
            end
            S_ALU_WB: begin
                result_sel = RES_ALU_OUT;
                rf_we      = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a_sel = A_RS1;
                alu_src_b_sel = B_IMM;
                state_d       = instr[5] ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                if (mem_ack) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                result_sel = RES_MEM;
                rf_we      = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_req      = 1'b1;
                mem_we       = 1'b1;
                mem_addr_sel = 1'b1;
                if (mem_ack) state_d = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_sel = A_RS1;
                alu_src_b_sel = B_RS2;
                alu_op        = OP_SUB;
                pc_sel        = 1'b1;
                pc_we         = (funct3 == 3'b000) ? alu_zero : !alu_zero;
                state_d       = S_FETCH;
            end
            S_JAL: begin
                // ALU passes PC (already PC+4) through as the link value.
                alu_src_a_sel = A_PC;
                alu_op        = OP_SRC1;
                result_sel    = RES_ALU;
                rf_we         = 1'b1;
                pc_sel        = 1'b1;
                pc_we         = 1'b1;
                state_d       = S_FETCH;
            end
            S_TRAP: begin
                illegal_d = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase

        // A reset cycle must not commit any architectural or memory side effect.
        if (rst) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            ir_we   = 1'b0;
            pc_we   = 1'b0;
            rf_we   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;
    assign state   = STATE_W'(state_q);

endmodule

// File: tb/tb_riscv_ctrl_fsm.sv
// Bench for riscv_ctrl_fsm: vector table, hand-written multi-cycle sequences and
// randomized instruction streams checked against an instruction-level reference model.
module tb_riscv_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        mem_ack = 1'b0;
    logic        alu_zero = 1'b0;
    logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, rf_we, illegal;
    logic [1:0]  alu_src_a_sel, alu_src_b_sel, result_sel;
    logic [2:0]  alu_op;
    logic [3:0]  state;

    int errors = 0;
    int checks = 0;

    riscv_ctrl_fsm #(.ALU_OP_W(3), .STATE_W(4)) dut (
        .clk(clk), .rst(rst), .instr(instr), .mem_ack(mem_ack), .alu_zero(alu_zero),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
        .pc_we(pc_we), .pc_sel(pc_sel), .alu_src_a_sel(alu_src_a_sel),
        .alu_src_b_sel(alu_src_b_sel), .alu_op(alu_op), .result_sel(result_sel),
        .rf_we(rf_we), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    logic [20:0] act;
    assign act = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, alu_src_a_sel,
                  alu_src_b_sel, alu_op, result_sel, rf_we, illegal, state};

    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JAL = 5, K_LUI = 6, K_ILL = 7;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Instruction-level classification by mnemonic: which class and which ALU op it needs.
    task automatic classify(input logic [31:0] i, output int kind, output int op);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = i[14:12];
        f7 = i[31:25];
        kind = K_ILL;
        op = 0;
        case (i[6:0])
            7'h33: begin
                if (f7 == 7'h20 && f3 == 3'd0) begin kind = K_R; op = 5; end
                else if (f7 == 7'h00) begin
                    case (f3)
                        3'd0: begin kind = K_R; op = 0; end
                        3'd6: begin kind = K_R; op = 1; end
                        3'd5: begin kind = K_R; op = 2; end
                        3'd1: begin kind = K_R; op = 3; end
                        3'd3: begin kind = K_R; op = 4; end
                        default: kind = K_ILL;
                    endcase
                end
            end
            7'h13: begin
                case (f3)
                    3'd0: begin kind = K_I; op = 0; end
                    3'd6: begin kind = K_I; op = 1; end
                    3'd3: begin kind = K_I; op = 4; end
                    3'd5: if (f7 == 7'h00) begin kind = K_I; op = 2; end
                    3'd1: if (f7 == 7'h00) begin kind = K_I; op = 3; end
                    default: kind = K_ILL;
                endcase
            end
            7'h03: kind = K_LD;
            7'h23: kind = K_ST;
            7'h63: if (f3 == 3'd0 || f3 == 3'd1) kind = K_BR;
            7'h6F: kind = K_JAL;
            7'h37: kind = K_LUI;
            default: kind = K_ILL;
        endcase
    endtask

    // Expected output bundle for a given spec state and inputs (all unlisted outputs are 0).
    function automatic logic [20:0] exp_out(input int st, input logic [31:0] i, input logic ack,
                                            input logic zero, input int op, input logic ill,
                                            input logic r);
        logic mreq, mwe, msel, irwe, pcwe, psel, rfwe;
        logic [1:0] a, b, rs;
        logic [2:0] aop;
        {mreq, mwe, msel, irwe, pcwe, psel, rfwe} = '0;
        a = 0; b = 0; rs = 0; aop = 0;
        case (st)
            0:  begin mreq = 1; b = 2; if (ack) begin irwe = 1; pcwe = 1; end end
            1:  begin a = 2; b = 1; end
            2:  begin a = 1; b = 1; end
            3:  begin mreq = 1; msel = 1; end
            4:  begin rs = 1; rfwe = 1; end
            5:  begin mreq = 1; mwe = 1; msel = 1; end
            6:  begin a = 1; aop = 3'(op); end
            7:  begin a = 1; b = 1; aop = 3'(op); end
            8:  rfwe = 1;
            9:  begin a = 1; aop = 5; psel = 1; pcwe = (i[14:12] == 3'd0) ? zero : !zero; end
            10: begin aop = 6; rs = 2; rfwe = 1; psel = 1; pcwe = 1; end
            11: begin a = 3; b = 1; end
            default: ;
        endcase
        if (r) {mreq, mwe, irwe, pcwe, rfwe} = '0;
        return {mreq, mwe, msel, irwe, pcwe, psel, a, b, aop, rs, rfwe, ill, 4'(st)};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] opc, f7;
        logic [2:0] f3;
        case ($urandom_range(0, 8))
            0, 8: opc = 7'h33;
            1: opc = 7'h13;
            2: opc = 7'h03;
            3: opc = 7'h23;
            4: opc = 7'h63;
            5: opc = 7'h6F;
            6: opc = 7'h37;
            default: opc = 7'($urandom);
        endcase
        case ($urandom_range(0, 3))
            0, 1: f7 = 7'h00;
            2: f7 = 7'h20;
            default: f7 = 7'($urandom);
        endcase
        f3 = 3'($urandom);
        return {f7, 5'($urandom), 5'($urandom), f3, 5'($urandom), opc};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic        zero;
        int          cyc;   // cycles back to FETCH with zero-wait memory; -1 = must trap
        int          op;    // ALU op seen in EXEC_R/EXEC_I; -1 = no exec state
        int          brwe;  // pc_we seen in BRANCH; -1 = no branch state
    } vec_t;

    vec_t vecs[$];
    int   kind, op, cyc, seen_op, seen_br, tcnt;
    int   q[$];
    logic ill_m;
    logic [31:0] cur;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs.push_back('{32'h002081B3, 1'b0, 4, 0, -1});   // ADD
        vecs.push_back('{32'h402081B3, 1'b0, 4, 5, -1});   // SUB
        vecs.push_back('{32'h0020E1B3, 1'b0, 4, 1, -1});   // OR
        vecs.push_back('{32'h002091B3, 1'b0, 4, 3, -1});   // SLL
        vecs.push_back('{32'h0020D1B3, 1'b0, 4, 2, -1});   // SRL
        vecs.push_back('{32'h0020B1B3, 1'b0, 4, 4, -1});   // SLTU
        vecs.push_back('{32'h0050B193, 1'b0, 4, 4, -1});   // SLTIU
        vecs.push_back('{32'h00508193, 1'b0, 4, 0, -1});   // ADDI
        vecs.push_back('{32'h0050E193, 1'b0, 4, 1, -1});   // ORI
        vecs.push_back('{32'h0050D193, 1'b0, 4, 2, -1});   // SRLI
        vecs.push_back('{32'h123451B7, 1'b0, 4, -1, -1});  // LUI
        vecs.push_back('{32'h0000A183, 1'b0, 5, -1, -1});  // LW
        vecs.push_back('{32'h0020A023, 1'b0, 4, -1, -1});  // SW
        vecs.push_back('{32'h00208063, 1'b1, 3, -1, 1});   // BEQ taken
        vecs.push_back('{32'h00209063, 1'b1, 3, -1, 0});   // BNE not taken
        vecs.push_back('{32'h00209063, 1'b0, 3, -1, 1});   // BNE taken
        vecs.push_back('{32'h000000EF, 1'b0, 3, -1, -1});  // JAL
        vecs.push_back('{32'h0020A1B3, 1'b0, -1, -1, -1}); // R funct3=010
        vecs.push_back('{32'h4020D1B3, 1'b0, -1, -1, -1}); // SRA
        vecs.push_back('{32'h0050C193, 1'b0, -1, -1, -1}); // XORI
        vecs.push_back('{32'h0020C063, 1'b0, -1, -1, -1}); // BLT
        vecs.push_back('{32'h0000007F, 1'b0, -1, -1, -1}); // bad opcode

        // Reset cycle and post-reset state
        @(negedge clk);
        #1;
        chk("rst_enables", {mem_req, mem_we, ir_we, pc_we, rf_we}, 5'b0);
        rst = 1'b0;
        #1;
        chk("rst_state", state, 4'd0);
        chk("rst_illegal", illegal, 1'b0);
        chk("fetch_req_after_rst", {mem_req, mem_addr_sel, ir_we}, 3'b100);

        for (int v = 0; v < vecs.size(); v++) begin
            do_reset();
            instr = vecs[v].instr;
            alu_zero = vecs[v].zero;
            mem_ack = 1'b1;
            cyc = -2; seen_op = -1; seen_br = -1;
            for (int c = 0; c < 12; c++) begin
                #1;
                if (c > 0 && state == 4'd0) begin cyc = c; break; end
                if (state == 4'd12) begin cyc = -1; break; end
                if (state == 4'd6 || state == 4'd7) seen_op = int'(alu_op);
                if (state == 4'd9) seen_br = int'(pc_we);
                @(negedge clk);
            end
            chk($sformatf("vec%0d_cycles", v), cyc, vecs[v].cyc);
            chk($sformatf("vec%0d_aluop", v), seen_op, vecs[v].op);
            chk($sformatf("vec%0d_brwe", v), seen_br, vecs[v].brwe);
        end

        // ADD trace: state path and rf_we only in ALU_WB
        begin
            int st_exp[5] = '{0, 1, 6, 8, 0};
            do_reset();
            instr = 32'h002081B3;
            mem_ack = 1'b1;
            for (int c = 0; c < 5; c++) begin
                #1;
                chk($sformatf("add_trace%0d", c), {state, rf_we}, {4'(st_exp[c]), 1'(st_exp[c] == 8)});
                @(negedge clk);
            end
        end

        // LW with 3 wait cycles in FETCH and in MEM_READ: 11 cycles
        begin
            int st_exp[12] = '{0, 0, 0, 0, 1, 2, 3, 3, 3, 3, 4, 0};
            do_reset();
            instr = 32'h0000A183;
            for (int c = 0; c < 12; c++) begin
                mem_ack = (c == 3 || c == 9);
                #1;
                chk($sformatf("lw_stall%0d", c),
                    {state, mem_req, mem_addr_sel, rf_we, result_sel, ir_we},
                    {4'(st_exp[c]), 1'(st_exp[c] == 0 || st_exp[c] == 3), 1'(st_exp[c] == 3),
                     1'(st_exp[c] == 4), 2'(st_exp[c] == 4), 1'(c == 3)});
                @(negedge clk);
            end
        end

        // Illegal opcode: TRAP is terminal, illegal sticky, no enables; rst clears
        do_reset();
        instr = 32'h0000007F;
        mem_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            mem_ack = c[0];
            alu_zero = c[1];
            #1;
            chk($sformatf("trap_state%0d", c), state, 4'd12);
            chk($sformatf("trap_enables%0d", c), {mem_req, mem_we, ir_we, pc_we, rf_we}, 5'b0);
            if (c > 0) chk($sformatf("trap_illegal%0d", c), illegal, 1'b1);
            @(negedge clk);
        end
        do_reset();
        #1;
        chk("trap_clear_state", state, 4'd0);
        chk("trap_clear_illegal", illegal, 1'b0);

        // Reset during a stalled MEM_WRITE
        @(negedge clk);
        instr = 32'h0020A023;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("sw_wait", {state, mem_req, mem_we}, {4'd5, 2'b11});
        @(negedge clk);
        rst = 1'b1;
        mem_ack = 1'b1;
        #1;
        chk("sw_rst_enables", {mem_req, mem_we, ir_we, pc_we, rf_we}, 5'b0);
        @(negedge clk);
        rst = 1'b0;
        mem_ack = 1'b0;
        #1;
        chk("sw_rst_state", state, 4'd0);

        // Randomized instruction stream against the reference model
        do_reset();
        ill_m = 1'b0;
        tcnt = 0;
        q.delete();
        for (int n = 0; n < 3000; n++) begin
            if (q.size() == 0) begin
                cur = rand_instr();
                classify(cur, kind, op);
                q.push_back(0);
                q.push_back(1);
                case (kind)
                    K_R:   begin q.push_back(6); q.push_back(8); end
                    K_I:   begin q.push_back(7); q.push_back(8); end
                    K_LUI: begin q.push_back(11); q.push_back(8); end
                    K_LD:  begin q.push_back(2); q.push_back(3); q.push_back(4); end
                    K_ST:  begin q.push_back(2); q.push_back(5); end
                    K_BR:  q.push_back(9);
                    K_JAL: q.push_back(10);
                    default: q.push_back(12);
                endcase
                instr = cur;
            end
            mem_ack = ($urandom_range(0, 2) != 0);
            alu_zero = 1'($urandom_range(0, 1));
            rst = (q[0] == 12 && tcnt >= 3);
            #1;
            chk("rand", act, exp_out(q[0], cur, mem_ack, alu_zero, op, ill_m, rst));
            if (rst) begin
                q.delete();
                ill_m = 1'b0;
                tcnt = 0;
            end else if (q[0] == 12) begin
                ill_m = 1'b1;
                tcnt++;
            end else if (!((q[0] == 0 || q[0] == 3 || q[0] == 5) && !mem_ack)) begin
                void'(q.pop_front());
            end
            @(negedge clk);
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
